// File: rtl/hdmi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// HdmiCfgSequencer (top module hdmi_cfg_sequencer)
//
// Walks a register table and writes every entry into an HDMI transmitter
// through an external I2C byte-write master. A pass starts automatically
// after reset, waits a settle delay, then issues one write per table entry
// in ascending order. A NACKed write is retried up to RETRY_MAX times
// before the sequencer gives up in ERROR.
//
// Optional feature macro: HDMI_CFG_INT_RESTART_EN
//   When defined, a rising edge on the transmitter interrupt (hot-plug)
//   restarts a pass. An edge seen while a pass is running is remembered
//   and honoured as soon as that pass ends. When undefined, the interrupt
//   input is ignored and no synchronizer or pending flag exists.
// -----------------------------------------------------------------------------
module hdmi_cfg_sequencer #(
    parameter int         NUM_REGS      = 16,
    parameter int         SETTLE_CYCLES = 50000,
    parameter int         RETRY_MAX     = 3,
    parameter logic [6:0] DEV_ADDR      = 7'h39
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        start,
    input  logic        interrupt,
    output logic [4:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev,
    output logic [7:0]  i2c_reg,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error
);

    // Counter widths are kept at least one bit so tiny parameter values
    // still produce legal vectors.
    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RC_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       LAST_INDEX  = 5'(NUM_REGS - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT = RC_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_settleCnt;
    logic [4:0]       r_index;
    logic [RC_W-1:0]  r_retryCnt;
    logic [4:0]       r_tblAddr;
    logic             r_i2cReq;
    logic [7:0]       r_i2cReg;
    logic [7:0]       r_i2cWdata;
    logic             r_busy;
    logic             r_cfgDone;
    logic             r_cfgError;

    logic             w_intRise;
    logic             w_pending;
    logic             w_restart;

`ifdef HDMI_CFG_INT_RESTART_EN
    logic r_intSync1;
    logic r_intSync2;
    logic r_intPrev;
    logic r_pending;

    // Two-flop synchronizer for the asynchronous interrupt plus one more
    // flop so a rising edge can be detected in the clock_50 domain.
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_intSync1 <= 1'b0;
            r_intSync2 <= 1'b0;
            r_intPrev  <= 1'b0;
        end else begin
            r_intSync1 <= interrupt;
            r_intSync2 <= r_intSync1;
            r_intPrev  <= r_intSync2;
        end
    end

    assign w_intRise = r_intSync2 & ~r_intPrev;

    // Remember an interrupt edge that arrives mid-pass; it is dropped once
    // the sequencer sits in DONE/ERROR, where the FSM has already used it
    // to restart in that same cycle.
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_pending <= 1'b0;
        end else if (r_busy && w_intRise) begin
            r_pending <= 1'b1;
        end else if (r_state == ST_DONE || r_state == ST_ERROR) begin
            r_pending <= 1'b0;
        end
    end

    assign w_pending = r_pending;
`else
    logic w_unusedInt;

    assign w_unusedInt = interrupt;
    assign w_intRise   = 1'b0;
    assign w_pending   = 1'b0;
`endif

    // A start pulse, a fresh interrupt edge or a remembered edge all map
    // onto the same single restart request.
    assign w_restart = start | w_intRise | w_pending;

    // Main sequencer: state, counters and all registered outputs move
    // together so the outputs never glitch between states.
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_settleCnt <= '0;
            r_index     <= '0;
            r_retryCnt  <= '0;
            r_tblAddr   <= '0;
            r_i2cReq    <= 1'b0;
            r_i2cReg    <= '0;
            r_i2cWdata  <= '0;
            r_busy      <= 1'b0;
            r_cfgDone   <= 1'b0;
            r_cfgError  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_SETTLE;
                    r_settleCnt <= '0;
                    r_index     <= '0;
                    r_retryCnt  <= '0;
                    r_busy      <= 1'b1;
                    r_cfgDone   <= 1'b0;
                    r_cfgError  <= 1'b0;
                end

                ST_SETTLE: begin
                    if (r_settleCnt == SETTLE_LAST) begin
                        r_state   <= ST_FETCH;
                        r_tblAddr <= r_index;
                    end else begin
                        r_settleCnt <= r_settleCnt + CNT_W'(1);
                    end
                end

                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_i2cReg   <= tbl_data[15:8];
                    r_i2cWdata <= tbl_data[7:0];
                    r_i2cReq   <= 1'b1;
                    r_state    <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    r_i2cReq <= 1'b1;
                    r_state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i2c_done) begin
                        r_i2cReq <= 1'b0;
                        if (!i2c_nack) begin
                            r_retryCnt <= '0;
                            if (r_index == LAST_INDEX) begin
                                r_state   <= ST_DONE;
                                r_busy    <= 1'b0;
                                r_cfgDone <= 1'b1;
                            end else begin
                                r_index   <= r_index + 5'd1;
                                r_tblAddr <= r_index + 5'd1;
                                r_state   <= ST_FETCH;
                            end
                        end else if (r_retryCnt < RETRY_LIMIT) begin
                            r_retryCnt <= r_retryCnt + RC_W'(1);
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_state    <= ST_ERROR;
                            r_busy     <= 1'b0;
                            r_cfgError <= 1'b1;
                        end
                    end
                end

                ST_DONE, ST_ERROR: begin
                    if (w_restart) begin
                        r_state     <= ST_SETTLE;
                        r_settleCnt <= '0;
                        r_index     <= '0;
                        r_retryCnt  <= '0;
                        r_busy      <= 1'b1;
                        r_cfgDone   <= 1'b0;
                        r_cfgError  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl_addr  = r_tblAddr;
    assign i2c_req   = r_i2cReq;
    assign i2c_dev   = DEV_ADDR;
    assign i2c_reg   = r_i2cReg;
    assign i2c_wdata = r_i2cWdata;
    assign busy      = r_busy;
    assign cfg_done  = r_cfgDone;
    assign cfg_error = r_cfgError;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for hdmi_cfg_sequencer (NUM_REGS=4, SETTLE_CYCLES=8, RETRY_MAX=2).
// Expected writes are queued by the stimulus; a monitor pops one entry per
// i2c_req rising edge. A simple master model answers each request after a
// few cycles with ACK/NACK taken from a script queue.
// -----------------------------------------------------------------------------
module tb_hdmi_cfg_sequencer;

    typedef struct packed {
        logic [7:0] regAddr;
        logic [7:0] data;
    } xact_t;

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        start;
    logic        interrupt;
    logic [4:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        i2c_req;
    logic [6:0]  i2c_dev;
    logic [7:0]  i2c_reg;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    xact_t       expQ[$];
    bit          nackQ[$];
    int          checks   = 0;
    int          failures = 0;

    logic [15:0] rom [0:3];
    logic        prevReq = 1'b0;
    xact_t       monExp;
    logic [15:0] monHeld;

    hdmi_cfg_sequencer #(
        .NUM_REGS      (4),
        .SETTLE_CYCLES (8),
        .RETRY_MAX     (2),
        .DEV_ADDR      (7'h39)
    ) dut (
        .clock_50  (clock_50),
        .reset     (reset),
        .start     (start),
        .interrupt (interrupt),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .i2c_req   (i2c_req),
        .i2c_dev   (i2c_dev),
        .i2c_reg   (i2c_reg),
        .i2c_wdata (i2c_wdata),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    // Free-running 100 MHz-style clock
    always #5 clock_50 = ~clock_50;

    // Register table behaves like a synchronous ROM: data one cycle after address
    always @(posedge clock_50) begin
        tbl_data <= (tbl_addr < 5'd4) ? rom[tbl_addr[1:0]] : 16'h0000;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushPass();
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(xact_t'(rom[i]));
        end
    endtask

    task automatic applyStimulus(input string what);
        $display("[TB] %s", what);
        @(negedge clock_50);
        start = 1'b1;
        @(negedge clock_50);
        start = 1'b0;
    endtask

    // Wait for cfg_done (which=0) or cfg_error (which=1) with a cycle budget
    task automatic waitFlag(input int which, input string name);
        int n;
        n = 0;
        @(negedge clock_50);
        while (((which == 0) ? cfg_done : cfg_error) !== 1'b1 && n < 600) begin
            @(negedge clock_50);
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: timeout, flag still 0, required 1", name);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " tbl_addr"},  32'(tbl_addr),  32'h0);
        checkOutput({tag, " i2c_req"},   32'(i2c_req),   32'h0);
        checkOutput({tag, " i2c_reg"},   32'(i2c_reg),   32'h0);
        checkOutput({tag, " i2c_wdata"}, 32'(i2c_wdata), 32'h0);
        checkOutput({tag, " busy"},      32'(busy),      32'h0);
        checkOutput({tag, " cfg_done"},  32'(cfg_done),  32'h0);
        checkOutput({tag, " cfg_error"}, 32'(cfg_error), 32'h0);
    endtask

    // I2C master model: answer each request about five cycles later
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clock_50);
            if (i2c_req) begin
                repeat (4) @(negedge clock_50);
                i2c_done = 1'b1;
                i2c_nack = (nackQ.size() > 0) ? nackQ.pop_front() : 1'b0;
                @(negedge clock_50);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compare each new write and its stability while held
    always @(negedge clock_50) begin
        if (i2c_req && !prevReq) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected write: got reg/data %h/%h, required none",
                         i2c_reg, i2c_wdata);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("write reg",  32'(i2c_reg),   32'(monExp.regAddr));
                checkOutput("write data", 32'(i2c_wdata), 32'(monExp.data));
                checkOutput("write dev",  32'(i2c_dev),   32'h39);
            end
            monHeld = {i2c_reg, i2c_wdata};
        end else if (i2c_req && prevReq) begin
            checkOutput("req hold stable", 32'({i2c_reg, i2c_wdata}), 32'(monHeld));
        end
        prevReq = i2c_req;
    end

    // Directed sequence
    initial begin
        int n;
        rom[0] = 16'h4110;
        rom[1] = 16'h9803;
        rom[2] = 16'h9AE0;
        rom[3] = 16'hD6C0;
        reset     = 1'b0;
        start     = 1'b0;
        interrupt = 1'b0;

        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        checkResetValues("reset");
        checkOutput("reset i2c_dev", 32'(i2c_dev), 32'h39);

        // Automatic first pass and its start-up latency
        $display("[TB] pass 1: automatic after reset release");
        pushPass();
        reset = 1'b1;
        @(posedge clock_50);
        n = 0;
        while (i2c_req !== 1'b1 && n < 100) begin
            @(posedge clock_50);
            #1;
            n++;
        end
        checkOutput("first req latency", 32'(n), 32'd10);
        waitFlag(0, "pass 1 done");
        checkOutput("pass 1 cfg_done",  32'(cfg_done),    32'h1);
        checkOutput("pass 1 busy",      32'(busy),        32'h0);
        checkOutput("pass 1 cfg_error", 32'(cfg_error),   32'h0);
        checkOutput("pass 1 queue",     32'(expQ.size()), 32'h0);

        // Two NACKs on entry 1, then ACK; a start pulse mid-pass is ignored
        expQ.push_back(xact_t'(rom[0]));
        repeat (3) expQ.push_back(xact_t'(rom[1]));
        expQ.push_back(xact_t'(rom[2]));
        expQ.push_back(xact_t'(rom[3]));
        nackQ = '{1'b0, 1'b1, 1'b1};
        applyStimulus("pass 2: retries on entry 1");
        repeat (20) @(negedge clock_50);
        applyStimulus("pass 2: start while busy");
        waitFlag(0, "pass 2 done");
        checkOutput("pass 2 cfg_done",  32'(cfg_done),    32'h1);
        checkOutput("pass 2 cfg_error", 32'(cfg_error),   32'h0);
        checkOutput("pass 2 queue",     32'(expQ.size()), 32'h0);

        // Entry 2 exhausts its retries
        expQ.push_back(xact_t'(rom[0]));
        expQ.push_back(xact_t'(rom[1]));
        repeat (3) expQ.push_back(xact_t'(rom[2]));
        nackQ = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        applyStimulus("pass 3: entry 2 always NACKed");
        waitFlag(1, "pass 3 error");
        checkOutput("pass 3 cfg_error", 32'(cfg_error), 32'h1);
        checkOutput("pass 3 busy",      32'(busy),      32'h0);
        checkOutput("pass 3 cfg_done",  32'(cfg_done),  32'h0);
        n = 0;
        repeat (30) begin
            @(negedge clock_50);
            if (i2c_req) n++;
        end
        checkOutput("error idle req cycles", 32'(n),           32'h0);
        checkOutput("pass 3 queue",          32'(expQ.size()), 32'h0);

        // Restart from ERROR
        pushPass();
        applyStimulus("pass 4: restart from error");
        waitFlag(0, "pass 4 done");
        checkOutput("pass 4 cfg_done",  32'(cfg_done),    32'h1);
        checkOutput("pass 4 cfg_error", 32'(cfg_error),   32'h0);
        checkOutput("pass 4 queue",     32'(expQ.size()), 32'h0);

`ifdef HDMI_CFG_INT_RESTART_EN
        // Interrupt during entry 1 queues a second pass
        pushPass();
        pushPass();
        applyStimulus("pass 5: interrupt mid-pass");
        n = 0;
        while (tbl_addr !== 5'd1 && n < 200) begin
            @(negedge clock_50);
            n++;
        end
        interrupt = 1'b1;
        repeat (3) @(negedge clock_50);
        interrupt = 1'b0;
        waitFlag(0, "pass 5 first done");
        checkOutput("pass 5 cfg_done", 32'(cfg_done), 32'h1);
        @(negedge clock_50);
        checkOutput("pass 5 done pulse", 32'(cfg_done), 32'h0);
        checkOutput("pass 5 busy again", 32'(busy),     32'h1);
        n = 1;
        while (i2c_req !== 1'b1 && n < 100) begin
            @(negedge clock_50);
            n++;
        end
        checkOutput("pass 5 restart latency", 32'(n), 32'd11);
        waitFlag(0, "pass 5 second done");
        checkOutput("pass 5 queue", 32'(expQ.size()), 32'h0);
`else
        // Interrupt has no effect in this build
        $display("[TB] interrupt ignored in DONE");
        @(negedge clock_50);
        interrupt = 1'b1;
        repeat (3) @(negedge clock_50);
        interrupt = 1'b0;
        repeat (20) @(negedge clock_50);
        checkOutput("interrupt busy",     32'(busy),        32'h0);
        checkOutput("interrupt cfg_done", 32'(cfg_done),    32'h1);
        checkOutput("interrupt queue",    32'(expQ.size()), 32'h0);
`endif

        // Reset while a write is outstanding
        expQ.push_back(xact_t'(rom[0]));
        applyStimulus("pass 6: reset during WAIT");
        n = 0;
        while (i2c_req !== 1'b1 && n < 100) begin
            @(negedge clock_50);
            n++;
        end
        @(negedge clock_50);
        reset = 1'b0;
        @(negedge clock_50);
        checkResetValues("mid reset");
        pushPass();
        reset = 1'b1;
        waitFlag(0, "pass 6 fresh done");
        checkOutput("pass 6 cfg_done",  32'(cfg_done),    32'h1);
        checkOutput("pass 6 cfg_error", 32'(cfg_error),   32'h0);
        checkOutput("pass 6 queue",     32'(expQ.size()), 32'h0);

        repeat (5) @(negedge clock_50);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdmi_cfg_sequencer.md
HDMI_CFG_SEQUENCER -- requirements
Module: hdmi_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16; number of register-table entries written per configuration pass (2..32).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 50000; power-up/hot-plug settle delay in clock_50 cycles.
REQ-003 SHALL have parameter RETRY_MAX, default 3; retries allowed per entry after a NACK.
REQ-004 SHALL have parameter DEV_ADDR, default 7'h39; 7-bit I2C address of the HDMI transmitter.
REQ-005 Port clock_50  in  1  sole clock; all logic on rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset.
REQ-007 Port start  in  1  single-cycle request to run a configuration pass.
REQ-008 Port interrupt  in  1  asynchronous transmitter interrupt, active-high level.
REQ-009 Port tbl_addr  out  5  register-table index.
REQ-010 Port tbl_data  in  16  table entry: [15:8] register address, [7:0] value; valid one cycle after tbl_addr changes.
REQ-011 Port i2c_req  out  1  write-transaction request to the I2C byte-write master.
REQ-012 Port i2c_dev  out  7  device address (always DEV_ADDR).
REQ-013 Port i2c_reg  out  8  register address of the current write.
REQ-014 Port i2c_wdata  out  8  data byte of the current write.
REQ-015 Port i2c_done  in  1  one-cycle pulse from master: transaction finished.
REQ-016 Port i2c_nack  in  1  NACK status, valid only in the cycle i2c_done is high.
REQ-017 Port busy  out  1  high from leaving IDLE/DONE/ERROR until re-entering one of them.
REQ-018 Port cfg_done  out  1  high while in DONE.
REQ-019 Port cfg_error  out  1  high while in ERROR.

Function
REQ-020 States SHALL be IDLE, SETTLE, FETCH, LATCH, ISSUE, WAIT, DONE, ERROR.
REQ-021 IDLE: after reset release SHALL go to SETTLE next cycle (automatic first pass); no other exit.
REQ-022 SETTLE: counter loads 0 on entry, enters FETCH when count reaches SETTLE_CYCLES-1; index and retry count cleared on entry.
REQ-023 FETCH: tbl_addr = index; next cycle LATCH captures tbl_data into i2c_reg/i2c_wdata, then ISSUE.
REQ-024 ISSUE: i2c_req rises; SHALL stay high with i2c_reg/i2c_wdata stable until the cycle i2c_done is sampled high (WAIT), deasserting the following cycle.
REQ-025 i2c_done with i2c_nack=0: retry count cleared; if index = NUM_REGS-1 go to DONE, else index+1 and FETCH.
REQ-026 i2c_done with i2c_nack=1: if retry count < RETRY_MAX, retry count+1 and re-enter ISSUE with the same entry; else go to ERROR.
REQ-027 i2c_done outside WAIT SHALL be ignored.
REQ-028 start SHALL restart a pass (to SETTLE) only from DONE or ERROR; ignored in all other states.
REQ-029 Minimum i2c_req low time between consecutive transactions SHALL be 1 cycle.
REQ-030 A pass of N entries without NACK SHALL issue exactly N transactions in ascending index order.

Reset
REQ-031 reset low at a clock edge SHALL force IDLE, index 0, counters 0, i2c_req 0, i2c_reg/i2c_wdata 0, tbl_addr 0, busy 0, cfg_done 0, cfg_error 0, pending flag 0, synchronizers 0.
REQ-032 Reset mid-transaction SHALL drop i2c_req the next cycle; the in-flight i2c_done SHALL be ignored after reset.

Configuration
REQ-033 Macro HDMI_CFG_INT_RESTART_EN, when defined: interrupt passes a 2-flop synchronizer; a rising edge in DONE or ERROR restarts a pass (SETTLE); a rising edge while busy sets a pending flag that forces a restart on DONE/ERROR entry, flag cleared then.
REQ-034 Without HDMI_CFG_INT_RESTART_EN: interrupt SHALL be ignored, no synchronizer or pending flag generated.
REQ-035 start and interrupt edge in the same cycle SHALL produce one restart.

Verification (NUM_REGS=4, SETTLE_CYCLES=8, RETRY_MAX=2)
REQ-036 Release reset, table {0x4110,0x9803,0x9AE0,0xD6C0}, master acks after 5 cycles -> 4 writes reg/data 41/10,98/03,9A/E0,D6/C0 in order, first i2c_req 10 cycles after release, cfg_done=1 after 4th.
REQ-037 NACK on entry 1 twice then ACK -> entry 1 issued 3 times with unchanged 98/03, pass completes, cfg_done=1.
REQ-038 NACK on entry 2 three times -> cfg_error=1, busy=0, no further i2c_req; start pulse -> full pass again from entry 0.
REQ-039 With HDMI_CFG_INT_RESTART_EN, interrupt rises during entry 1 -> current pass finishes, cfg_done pulses 1 cycle, second pass begins after 8 settle cycles.
REQ-040 reset low while i2c_req high in WAIT -> i2c_req 0 next cycle, all outputs at reset values, late i2c_done ignored, fresh pass after release.
